// File: rtl/uart_fmt_pkg.sv
// Shared formatting constants, FSM encoding and BCD helpers for the UART
// text senders.
package uart_fmt_pkg;

  localparam int DIGITS = 10;
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT_ON,
    EMIT_OFF
  } state_t;

  function automatic logic [BCD_W-1:0] dd_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] nib_at(
    input logic [BCD_W-1:0] b,
    input logic [3:0]       sel
  );
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == 4'(i))
        r = b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [3:0] top_digit(
    input logic [BCD_W-1:0] b
  );
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'h0)
        r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32 shift/adjust iterations, one per clock,
// with a one-cycle done pulse after the last one.
module bin2bcd_seq
  import uart_fmt_pkg::*;
(
  input  logic             mclk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [31:0]      shreg;
  logic [4:0]       cnt;
  logic             run;
  logic [BCD_W-1:0] adj;

  assign adj = dd_adj(bcd);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= bin;
        bcd   <= '0;
        cnt   <= '0;
        run   <= 1'b1;
      end else if (run) begin
        {bcd, shreg} <= {adj, shreg} << 1;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/send_uint32_dec_tx_buf.sv
// 32-bit value to ASCII decimal sender feeding uart_buffer, paced by baud_x1.
// Build option: DEC_SIGNED_EN treats data as two's complement with '-' prefix.
module send_uint32_dec_tx_buf
  import uart_fmt_pkg::*;
#(
  parameter bit EOL_CRLF = 1'b1
)(
  input  logic        mclk,
  input  logic        reset,
  input  logic        baud_x1,
  input  logic [31:0] data,
  input  logic        data_strobe,
  output logic [7:0]  curr_char,
  output logic        send_strobe,
  output logic        busy
);

`ifdef DEC_SIGNED_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif

  state_t           state, state_n;
  logic             data_strobe_d;
  logic             req, start, done, emit, unstrobe;
  logic [31:0]      mag;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       fd;
  logic [CW-1:0]    idx, k, n_chars;
  logic [7:0]       ch;
  logic             neg;

`ifdef DEC_SIGNED_EN
  assign mag = data[31] ? (~data + 32'd1) : data;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)     neg <= 1'b0;
    else if (start) neg <= data[31];
  end
`else
  assign mag = data;
  assign neg = 1'b0;
`endif

  bin2bcd_seq u_bcd (
    .mclk  (mclk),
    .reset (reset),
    .start (start),
    .bin   (mag),
    .done  (done),
    .bcd   (bcd)
  );

  assign req     = data_strobe & ~data_strobe_d;
  assign busy    = (state != IDLE);
  assign n_chars = CW'(neg) + CW'(fd) + CW'(1)
                 + (EOL_CRLF ? CW'(2) : CW'(0));
  assign k       = idx - CW'(neg);

  always_comb begin
    ch = CH_LF;
    unique case (1'b1)
      (neg && idx == '0):
        ch = CH_MINUS;
      (k <= CW'(fd)):
        ch = CH_0 | {4'h0, nib_at(bcd, fd - k[3:0])};
      (k == CW'(fd) + CW'(1)):
        ch = CH_CR;
      default:
        ch = CH_LF;
    endcase
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    emit     = 1'b0;
    unstrobe = 1'b0;
    case (state)
      IDLE:
        if (req) begin
          start   = 1'b1;
          state_n = CONVERT;
        end
      CONVERT:
        if (done) state_n = EMIT_ON;
      EMIT_ON:
        if (baud_x1) begin
          emit    = 1'b1;
          state_n = EMIT_OFF;
        end
      EMIT_OFF:
        if (baud_x1) begin
          unstrobe = 1'b1;
          state_n  = (idx == n_chars) ? IDLE : EMIT_ON;
        end
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      data_strobe_d <= 1'b0;
      curr_char     <= 8'h00;
      send_strobe   <= 1'b0;
      idx           <= '0;
      fd            <= 4'h0;
    end else begin
      state         <= state_n;
      data_strobe_d <= data_strobe;
      if (start) idx <= '0;
      if (done)  fd  <= top_digit(bcd);
      if (emit) begin
        curr_char   <= ch;
        send_strobe <= 1'b1;
        idx         <= idx + CW'(1);
      end
      if (unstrobe) send_strobe <= 1'b0;
    end
  end

endmodule

// File: doc/send_uint32_dec_tx_buf.md
Name: send_uint32_dec_tx_buf

Overview:
- Converts a 32-bit binary value to ASCII decimal, leading zeros suppressed, optional CR LF terminator.
- Sits directly upstream of the uart_buffer TX ring buffer. Drives its data/data_strobe inputs one character at a time, paced by the shared baud_x1 tick.
- Decimal counterpart of the existing hex-digit sender. Conversion is a sequential double-dabble.

Parameters:
- EOL_CRLF, 1, when 1 append 0x0D then 0x0A after the digits; when 0 emit digits only.
- DIGITS, 10, BCD digit count; fixed by the 32-bit input width (max 4294967295).

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- baud_x1  in  1  one-mclk-wide pacing tick from uart_clk
- data  in  32  value to print
- data_strobe  in  1  request; rising edge, detected on mclk, starts a conversion
- curr_char  out  8  character presented to uart_buffer.data
- send_strobe  out  1  to uart_buffer.data_strobe
- busy  out  1  high from accepted request until final strobe low phase completes

Behaviour:
- Reset (reset=0, async): state=IDLE, curr_char=0x00, send_strobe=0, busy=0, edge-detect register=0, BCD/shift registers=0.
- Edge detect: data_strobe_d is registered every mclk. A request is data_strobe & ~data_strobe_d.
- IDLE: on request, latch data into a 32-bit shift register, clear the 40-bit BCD register, set busy=1, go to CONVERT the next cycle.
  - A request while busy is dropped (no queueing, no side effects).
- CONVERT: one iteration per mclk, not gated by baud_x1; exactly 32 cycles.
  - Each iteration: every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
  - After the 32nd iteration, compute first_digit = index of the most significant nonzero nibble (0 if value is 0). Go to EMIT_ON.
- EMIT_ON: wait for baud_x1. On the tick: curr_char <= next character, send_strobe <= 1, go to EMIT_OFF.
- EMIT_OFF: wait for baud_x1. On the tick: send_strobe <= 0.
  - If characters remain, go to EMIT_ON. Otherwise go to IDLE with busy <= 0.
- Character timing: each character occupies exactly two baud_x1 ticks, strobe high for one tick interval and low for the next. curr_char holds stable until the next EMIT_ON tick, so uart_buffer's delayed write samples the correct byte.
- Character sequence: digits from first_digit down to digit 0, each as 0x30|nibble. Then CR (0x0D) and LF (0x0A) if EOL_CRLF=1.
  - Value 0 emits a single "0".
  - Length is 1 to 10 digits, plus 2 for CRLF (plus 1 sign with the optional feature); at most 13 characters.
- Latency from request to first strobe: 1 (latch) + 32 (convert) + wait for the next baud_x1 tick.
- data may change after the request edge; only the latched copy is used.
- Reset asserted mid-conversion or mid-emission aborts immediately. send_strobe drops asynchronously and no partial character is retried.
- baud_x1 coinciding with the last CONVERT cycle is not used; emission starts on the following tick.

Optional Feature:
- Macro DEC_SIGNED_EN.
- Defined: data is two's complement.
  - If data[31]=1, the magnitude is (~data+1) as a 32-bit unsigned; 0x80000000 gives 2147483648.
  - A '-' (0x2D) is emitted before the first digit, using the same two-tick pacing.
  - Character counter widened by 1.
- Undefined: data is always unsigned and no sign logic is synthesized.

Decomposition:
- Shared package, uart_fmt_pkg:
  - ASCII constants: CH_0=0x30, CH_CR=0x0D, CH_LF=0x0A, CH_MINUS=0x2D.
  - State encoding: IDLE, CONVERT, EMIT_ON, EMIT_OFF.
  - DIGITS constant.
- Sub-module bin2bcd_seq:
  - Interface: start, bin[31:0] in; done, bcd[39:0] out.
  - Contains the 32-cycle double-dabble and its iteration counter. The top level owns edge detect, digit selection and pacing.

Test Plan:
- data=0x00000000, EOL_CRLF=1 -> characters 0x30,0x0D,0x0A; each strobe high exactly one baud interval; busy drops after the LF low phase.
- data=0xFFFFFFFF -> "4294967295" then CRLF, 12 strobes; first strobe no earlier than 33 mclk after the request edge.
- data=1000 with EOL_CRLF=0 -> "1000" only (4 strobes). Confirms internal zeros are kept and leading zeros dropped.
- Second data_strobe edge (data=7) during emission of 123 -> output is only "123"+CRLF; no '7' ever appears; busy stays high throughout.
- reset pulled low during the 3rd character of 4294967295 -> send_strobe=0, busy=0 asynchronously. A new request for 5 afterwards gives "5"+CRLF.
- With DEC_SIGNED_EN, data=0xFFFFFFFF -> "-1"+CRLF; data=0x80000000 -> "-2147483648"+CRLF (13 characters). Without the macro, 0xFFFFFFFF -> "4294967295".
